// File: rtl/id_seq.sv
// id_seq: sequenced instruction decoder; latches an instruction and steps a one-hot stage counter.
// Defining ID_DBG_EN adds dbg_halt/dbg_active and a HALT state entered between instructions.
module id_seq #(
    parameter int XLEN   = 16,
    parameter int REG_AW = 4,
    parameter int NSTAGE = 4,
    localparam int INST_W = XLEN + 3 * REG_AW + 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inst_valid,
    input  logic [INST_W-1:0] inst,
    output logic              inst_ready,
    input  logic              stall,
    output logic [NSTAGE-1:0] stage,
    output logic [3:0]        opc,
    output logic [REG_AW-1:0] sa1,
    output logic [REG_AW-1:0] sa2,
    output logic [REG_AW-1:0] da,
    output logic [XLEN-1:0]   imm,
    output logic [3:0]        alu_ctrl,
    output logic              pfc_ctrl,
    output logic              s2_sel,
    output logic [2:0]        din_sel,
    output logic [4:0]        addr_sel,
    output logic              sp_ctrl,
    output logic              done,
    output logic              illegal
`ifdef ID_DBG_EN
    ,
    input  logic              dbg_halt,
    output logic              dbg_active
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    localparam logic [3:0] OP_CALC  = 4'b0000;
    localparam logic [3:0] OP_CALCI = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0011;
    localparam logic [3:0] OP_STORE = 4'b0111;
    localparam logic [3:0] OP_CALIF = 4'b1111;

    state_t            state, state_n;
    logic [NSTAGE-1:0] stage_n;
    logic [INST_W-1:0] inst_q;
    logic              halt_q, halt_req, dbg_in, halted, accept, legal, en;
    logic              is_calc, is_calci, is_load, is_store, is_calif;

`ifdef ID_DBG_EN
    assign dbg_in     = dbg_halt;
    assign halted     = (state == HALT);
    assign dbg_active = halted;
`else
    assign dbg_in = 1'b0;
    assign halted = 1'b0;
`endif

    // A halt request sampled during RUN is remembered until the instruction retires
    assign halt_req   = halt_q || dbg_in;
    assign inst_ready = (state == IDLE && !dbg_in) ||
                        (state == RUN && stage[NSTAGE-1] && !stall && !halt_req);
    assign accept     = inst_valid && inst_ready;
    assign done       = stage[NSTAGE-1] && !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            stage  <= '0;
            inst_q <= '0;
            halt_q <= 1'b0;
        end else begin
            state  <= state_n;
            stage  <= stage_n;
            halt_q <= (state_n == RUN) && halt_req;
            if (accept) inst_q <= inst;
        end
    end

    always_comb begin
        state_n = state;
        stage_n = stage;
        if (state == IDLE) begin
            state_n = accept ? RUN : dbg_in ? HALT : IDLE;
            stage_n = accept ? NSTAGE'(1) : '0;
        end else if (state == RUN) begin
            if (!stall && stage[NSTAGE-1]) begin
                state_n = accept ? RUN : halt_req ? HALT : IDLE;
                stage_n = accept ? NSTAGE'(1) : '0;
            end else if (!stall) begin
                stage_n = stage << 1;
            end
        end else begin
            state_n = dbg_in ? HALT : IDLE;
        end
    end

    assign {imm, da, sa2, sa1, opc} = inst_q;

    assign is_calc  = (opc == OP_CALC);
    assign is_calci = (opc == OP_CALCI);
    assign is_load  = (opc == OP_LOAD);
    assign is_store = (opc == OP_STORE);
    assign is_calif = (opc == OP_CALIF);
    assign legal    = is_calc || is_calci || is_load || is_store || is_calif;
    assign illegal  = (state == RUN) && !legal;
    assign en       = (state == RUN) && legal;

    always_comb begin
        alu_ctrl = !en ? 4'b0000 : is_calc ? imm[3:0] : is_calci ? 4'(sa2) : 4'b0000;
        pfc_ctrl = en && is_calif;
        s2_sel   = en && !is_calc;
        din_sel  = !en ? 3'b000 : (is_calc || is_calci) ? 3'b001 :
                   (is_load || is_store) ? 3'b010 : 3'b100;
        sp_ctrl  = en && is_calif && stage[2];
        addr_sel = halted ? 5'b10000 : !en ? 5'b00000 :
                   stage[0] ? 5'b00010 :
                   stage[1] ? (is_load ? 5'b00001 : 5'b00100) :
                   stage[2] ? (is_store ? 5'b00001 : 5'b01000) : 5'b00000;
    end
endmodule

// File: tb/tb_id_seq.sv
// tb_id_seq: randomized scoreboard bench for id_seq against a stage-by-stage decode model.
module tb_id_seq;
    localparam int NSTAGE = 4;

    logic        clk = 0, rst_n = 0, inst_valid = 0, stall = 0;
    logic [31:0] inst = 0;
    logic        inst_ready, pfc_ctrl, s2_sel, sp_ctrl, done, illegal;
    logic [3:0]  stage, opc, sa1, sa2, da, alu_ctrl;
    logic [15:0] imm;
    logic [2:0]  din_sel;
    logic [4:0]  addr_sel;
`ifdef ID_DBG_EN
    logic        dbg_halt = 0, dbg_active;
`endif

    id_seq dut (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst(inst),
        .inst_ready(inst_ready), .stall(stall), .stage(stage), .opc(opc),
        .sa1(sa1), .sa2(sa2), .da(da), .imm(imm), .alu_ctrl(alu_ctrl),
        .pfc_ctrl(pfc_ctrl), .s2_sel(s2_sel), .din_sel(din_sel),
        .addr_sel(addr_sel), .sp_ctrl(sp_ctrl), .done(done), .illegal(illegal)
`ifdef ID_DBG_EN
        , .dbg_halt(dbg_halt), .dbg_active(dbg_active)
`endif
    );

    typedef struct {logic [31:0] w; int k;} rec_t;
    typedef struct packed {
        logic [3:0] alu; logic pfc; logic s2; logic [2:0] din; logic [4:0] addr; logic sp; logic ill;
    } dec_t;

    rec_t       q[$];
    int         errors = 0, checks = 0, cyc = 0;
    bit         rand_stall = 0, halt_mode = 0;
    logic [3:0] ops [5] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF};

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected decode of instruction w in stage k, written from the opcode table
    function automatic dec_t ref_dec(input logic [31:0] w, input int k);
        dec_t       d = '0;
        logic [3:0] op = w[3:0];
        case (op)
            4'h0: begin d.alu = w[19:16]; d.din = 3'b001; end
            4'h1: begin d.alu = w[11:8]; d.s2 = 1; d.din = 3'b001; end
            4'h3, 4'h7: begin d.s2 = 1; d.din = 3'b010; end
            4'hF: begin d.s2 = 1; d.din = 3'b100; d.pfc = 1; d.sp = (k == 2); end
            default: d.ill = 1;
        endcase
        if (!d.ill)
            d.addr = k == 0 ? 5'b00010 : k == 1 ? (op == 4'h3 ? 5'b00001 : 5'b00100) :
                     k == 2 ? (op == 4'h7 ? 5'b00001 : 5'b01000) : 5'b00000;
        return d;
    endfunction

    // Offer w until accepted; on the accepting edge queue one record per stage
    task automatic issue(input logic [31:0] w);
        int n = 0;
        inst = w;
        inst_valid = 1;
        @(negedge clk);
        while (!inst_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!inst_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: inst_ready stayed %b for inst %h", inst_ready, w);
            inst_valid = 0;
        end else begin
            @(posedge clk);
            for (int k = 0; k < NSTAGE; k++) q.push_back('{w, k});
        end
        #1;
    endtask

    task automatic lat(input string name, input int t0, input int exp_cyc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 40);
        chk(name, cyc - t0, exp_cyc);
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_stall) stall = ($urandom_range(3) == 0);
    end

    rec_t r;
    dec_t e;
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (stage == 0) begin
                chk("idle_pending", q.size(), 0);
                chk("idle_ctrl", {done, illegal, alu_ctrl, pfc_ctrl, s2_sel, din_sel, sp_ctrl, addr_sel[3:0]}, 0);
            end else if (q.size() == 0) begin
                chk("unexpected_stage", stage, 0);
            end else if (stall) begin
                chk("stall_hold", stage, 1 << q[0].k);
                chk("stall_ready_done", {inst_ready, done}, 0);
            end else begin
                r = q.pop_front();
                e = ref_dec(r.w, r.k);
                chk("stage", stage, 1 << r.k);
                chk("fields", {imm, da, sa2, sa1, opc}, r.w);
                chk("decode", {alu_ctrl, pfc_ctrl, s2_sel, din_sel, addr_sel, sp_ctrl, illegal}, e);
                chk("done", done, r.k == NSTAGE - 1);
                chk("ready", inst_ready, r.k == NSTAGE - 1 && !halt_mode);
            end
        end
    end

    initial begin
        int n, t0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {stage, done, illegal, addr_sel, din_sel}, 0);
        chk("reset_inst_q", {imm, da, sa2, sa1, opc}, 0);
        rst_n = 1;
        @(negedge clk);
        chk("ready_after_rst", inst_ready, 1);
        @(posedge clk);
        #1;

        issue(32'h0005_3214);
        t0 = cyc;
        inst_valid = 0;
        lat("illegal_done_lat", t0, NSTAGE - 1);

        issue(32'h1234_5213);
        inst_valid = 0;
        repeat (5) @(posedge clk);
        #1;

        issue(32'h00AB_6547);
        issue(32'h0000_321F);
        inst_valid = 0;
        repeat (6) @(posedge clk);
        #1;

        issue(32'h0000_0A71);
        t0 = cyc;
        inst_valid = 0;
        @(posedge clk);
        #1 stall = 1;
        repeat (3) @(posedge clk);
        #1 stall = 0;
        lat("stall_done_lat", t0, NSTAGE - 1 + 3);

        issue(32'h5678_9AB0);
        inst_valid = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stage !== 4'b0100 && n < 20);
        #1 rst_n = 0;
        #1 chk("rst_abort", {stage, done, illegal, addr_sel, din_sel, alu_ctrl, sp_ctrl}, 0);
        chk("rst_inst_q", {imm, da, sa2, sa1, opc}, 0);
        q.delete();
        @(negedge clk);
        chk("rst_no_done", {done, stage}, 0);
        @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("rst_ready", inst_ready, 1);
        @(posedge clk);
        #1;

        rand_stall = 1;
        for (int i = 0; i < 150; i++) begin
            logic [31:0] w;
            w = $urandom;
            w[3:0] = ($urandom_range(4) == 0) ? 4'($urandom) : ops[$urandom_range(4)];
            issue(w);
            if ($urandom_range(1) == 0) begin
                inst_valid = 0;
                n = $urandom_range(3);
                repeat (n) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        inst_valid = 0;
        rand_stall = 0;
        stall = 0;
        n = 0;
        while ((q.size() != 0 || stage != 0) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", q.size(), 0);

`ifdef ID_DBG_EN
        issue(32'h1234_5213);
        inst_valid = 0;
        @(posedge clk);
        #1;
        dbg_halt = 1;
        halt_mode = 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dbg_active && n < 20);
        chk("halt_enter", {dbg_active, inst_ready, stage}, 6'b100000);
        chk("halt_addr", addr_sel, 5'b10000);
        @(posedge clk);
        #1 dbg_halt = 0;
        @(negedge clk);
        chk("halt_hold", dbg_active, 1);
        @(negedge clk);
        chk("halt_exit", {dbg_active, inst_ready}, 2'b01);
        halt_mode = 0;
        @(posedge clk);
        #1 dbg_halt = 1;
        @(negedge clk);
        chk("idle_halt_wait", dbg_active, 0);
        @(negedge clk);
        chk("idle_halt_enter", dbg_active, 1);
        @(posedge clk);
        #1 dbg_halt = 0;
        @(negedge clk);
        @(negedge clk);
        chk("idle_halt_exit", dbg_active, 0);
        @(posedge clk);
        #1;
`endif

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
